count_ctrl: RTL

Sequencing controller for the hex counter display path: owns the 4-bit count value that feeds the 7-segment hex decoder and drives the status LEDs. Converts three board push-buttons into one-cycle commands for start/pause, load and direction. Advances the count on a prescaled tick from the board clock.

---
 rtl/count_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/count_ctrl.sv
// count_ctrl: hex counter sequencer; start/pause, load and direction keys drive a prescaled 4-bit count.
// Latency: key sampled low at edge N acts at edge N+2 (N+2+DB when COUNT_CTRL_DEBOUNCE_EN is defined).
// Backpressure: none; every key event and every prescaler tick is acted on in the cycle it occurs.
module count_ctrl #(
  parameter int DIV = 50_000_000,
  parameter int DB  = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] k,
  input  logic [3:0] s,
  output logic [3:0] q,
  output logic [9:0] l
);

  localparam int            PW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  logic [2:0]    sync1, sync2, lvl, prev, armed, ev;
  logic [1:0]    live;
  state_t        state, state_n;
  logic [PW-1:0] p, p_n;
  logic [3:0]    q_n;
  logic          dir, dir_n, wrap, wrap_n, tick;

  // Two-flop synchronizer; reset presets make every key look released.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= k;
      sync2 <= sync1;
    end
  end

  // A key is armed only once a real post-reset sample shows it released, so a
  // key held through reset cannot fake a press when the presets wash out.
  always_ff @(posedge clk) begin
    if (rst) begin
      live  <= '0;
      armed <= '0;
    end else begin
      live  <= {live[0], 1'b1};
      armed <= armed | (sync2 & {3{live[1]}});
    end
  end

`ifdef COUNT_CTRL_DEBOUNCE_EN
  localparam int            DW   = (DB > 1) ? $clog2(DB) : 1;
  localparam logic [DW-1:0] DMAX = DW'(DB - 1);

  logic [DW-1:0] dcnt [3];
  logic [2:0]    filt;

  // Filtered level follows the synced level only after DB consecutive differing cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt <= '1;
      for (int i = 0; i < 3; i++) dcnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == filt[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DMAX) begin
          filt[i] <= sync2[i];
          dcnt[i] <= '0;
        end else begin
          dcnt[i] <= dcnt[i] + DW'(1);
        end
      end
    end
  end

  assign lvl = filt;
`else
  // DB only matters for the filtered build.
  logic unused_db;
  assign unused_db = (DB != 0);
  assign lvl = sync2;
`endif

  // Previous level for falling-edge (press) detection.
  always_ff @(posedge clk) begin
    if (rst) prev <= '1;
    else     prev <= lvl;
  end

  assign ev = ~lvl & prev & armed;

  // Next state: start/pause FSM, prescaler, count step, load and wrap flag.
  always_comb begin
    state_n = state;
    p_n     = p;
    q_n     = q;
    dir_n   = dir ^ ev[2];
    wrap_n  = wrap;
    tick    = (state == RUN) && (p == PMAX);

    if (state == RUN) p_n = tick ? '0 : p + PW'(1);

    // Any start/pause event clears the wrap flag; a step below may set it again.
    if (ev[0]) begin
      wrap_n = 1'b0;
      case (state)
        IDLE: begin
          state_n = RUN;
          p_n     = '0;
        end
        RUN:     state_n = PAUSE;
        PAUSE:   state_n = RUN;
        default: state_n = IDLE;
      endcase
    end

    // Load overrides a coincident step; the step always uses the old direction.
    if (ev[1]) begin
      q_n    = s;
      p_n    = '0;
      wrap_n = 1'b0;
    end else if (tick) begin
      if (dir) begin
        q_n = q - 4'd1;
        if (q == 4'd0) wrap_n = 1'b1;
      end else begin
        q_n = q + 4'd1;
        if (q == 4'd15) wrap_n = 1'b1;
      end
    end
  end

  // State and output registers; l is built from next values so l[3:0] tracks q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      p     <= '0;
      q     <= '0;
      dir   <= 1'b0;
      wrap  <= 1'b0;
      l     <= '0;
    end else begin
      state <= state_n;
      p     <= p_n;
      q     <= q_n;
      dir   <= dir_n;
      wrap  <= wrap_n;
      l     <= {3'b000, wrap_n, (state_n == RUN), dir_n, q_n};
    end
  end

endmodule
